// File: rtl/spi_target_byte.sv
// spi_target_byte: SPI mode-0 target endpoint, MSB first, full duplex.
//
// The whole block runs in the clk_i domain. CS/SCK/MOSI are brought in through
// SYNC_STAGES-deep synchronisers; SCK and CS also get one history flop so that
// their edges can be detected. One byte of RX buffering and one byte of TX
// holding are exposed to the host side.
//
// Ports
//   clk_i          system clock
//   rst_i          synchronous reset, active high
//   spi_cs_n_i     target select from pin, active low, asynchronous
//   spi_sck_i      SPI clock from pin, asynchronous, idles low
//   spi_mosi_i     data from master
//   spi_miso_o     data to master
//   spi_miso_oe_o  MISO output enable, high only while selected
//   tx_data_i      byte to queue for transmission
//   tx_load_i      1-cycle strobe: write tx_data_i into the holding register
//   tx_ready_o     holding register empty, tx_load_i will be accepted
//   rx_data_o      last received byte
//   rx_valid_o     rx_data_o not yet read
//   rx_read_i      1-cycle strobe: consume rx_data_o
//   status_clr_i   clears rx_overrun_o and tx_underrun_o
//   rx_overrun_o   sticky: a byte completed while rx_data_o was still unread
//   tx_underrun_o  sticky: FILL_BYTE was shifted because holding was empty
//   txn_active_o   a CS frame is in progress
//   txn_end_o      1-cycle pulse when the frame ends (synchronised CS rise)
module spi_target_byte #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  FILL_BYTE   = 8'hFF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       spi_cs_n_i,
  input  logic       spi_sck_i,
  input  logic       spi_mosi_i,
  output logic       spi_miso_o,
  output logic       spi_miso_oe_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_load_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_read_i,
  input  logic       status_clr_i,
  output logic       rx_overrun_o,
  output logic       tx_underrun_o,
  output logic       txn_active_o,
  output logic       txn_end_o
);

  typedef enum logic [0:0] {
    StIdle,
    StActive
  } state_e;

  // ---------------------------------------------------------------------------
  // Input synchronisers and edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] sck_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   cs_hist_q;
  logic                   sck_hist_q;

  // The CS chain resets to "selected" (0). If reset lands in the middle of a
  // frame the pin is still low, so no fall is seen until CS has gone high and
  // low again; if CS is high the chain just shows a rise, which IDLE ignores.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cs_sync_q   <= '0;
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      cs_hist_q   <= 1'b0;
      sck_hist_q  <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n_i};
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
      cs_hist_q   <= cs_sync_q[SYNC_STAGES-1];
      sck_hist_q  <= sck_sync_q[SYNC_STAGES-1];
    end
  end

  logic cs_s;
  logic sck_s;
  logic mosi_s;
  logic cs_fall;
  logic cs_rise;
  logic sck_rise;
  logic sck_fall;

  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign cs_fall  = ~cs_s & cs_hist_q;
  assign cs_rise  = cs_s & ~cs_hist_q;
  assign sck_rise = sck_s & ~sck_hist_q;
  assign sck_fall = ~sck_s & sck_hist_q;

  // ---------------------------------------------------------------------------
  // Transaction state
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [7:0]  hold_q, hold_d;
  logic        tx_ready_q, tx_ready_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        rx_overrun_q, rx_overrun_d;
  logic        tx_underrun_q, tx_underrun_d;
  logic        miso_q, miso_d;
  logic        miso_oe_q, miso_oe_d;
  logic        txn_active_q, txn_active_d;
  logic        txn_end_q, txn_end_d;

  logic [7:0]  rx_byte;
  logic [7:0]  reload_byte;
  logic        do_reload;
  logic        byte_done;
  logic        overrun_set;
  logic        underrun_set;

  // Complete byte as it will stand after the current SCK rise is absorbed.
  assign rx_byte = {rx_shift_q[6:0], mosi_s};

  // tx_ready_q high means the holding register is empty.
  assign reload_byte = tx_ready_q ? FILL_BYTE : hold_q;

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    hold_d        = hold_q;
    tx_ready_d    = tx_ready_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    rx_overrun_d  = rx_overrun_q;
    tx_underrun_d = tx_underrun_q;
    miso_d        = miso_q;
    miso_oe_d     = miso_oe_q;
    txn_active_d  = txn_active_q;
    txn_end_d     = 1'b0;
    do_reload     = 1'b0;
    byte_done     = 1'b0;
    overrun_set   = 1'b0;
    underrun_set  = 1'b0;

    case (state_q)
      StIdle: begin
        if (cs_fall) begin
          state_d      = StActive;
          txn_active_d = 1'b1;
          miso_oe_d    = 1'b1;
          bit_cnt_d    = 3'd0;
          do_reload    = 1'b1;
        end
      end
      StActive: begin
        // CS rise wins over any SCK edge seen in the same cycle.
        if (cs_rise) begin
          state_d      = StIdle;
          bit_cnt_d    = 3'd0;
          rx_shift_d   = 8'h00;
          miso_oe_d    = 1'b0;
          miso_d       = 1'b1;
          txn_active_d = 1'b0;
          txn_end_d    = 1'b1;
        end else if (sck_rise) begin
          rx_shift_d = rx_byte;
          bit_cnt_d  = bit_cnt_q + 3'd1;
          byte_done  = (bit_cnt_q == 3'd7);
        end else if (sck_fall) begin
          if (bit_cnt_q != 3'd0) begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
            miso_d     = tx_shift_q[6];
          end else begin
            // Byte boundary: the next byte starts driving on this fall.
            do_reload = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Holding -> shift transfer (frame start and every byte boundary).
    if (do_reload) begin
      tx_shift_d   = reload_byte;
      miso_d       = reload_byte[7];
      underrun_set = tx_ready_q;
      tx_ready_d   = 1'b1;
    end

    // Host write. Evaluated after the reload so that a load accepted in the
    // same cycle as a reload leaves the holding register full.
    if (tx_load_i && tx_ready_q) begin
      hold_d     = tx_data_i;
      tx_ready_d = 1'b0;
    end

    if (rx_read_i && rx_valid_q) begin
      rx_valid_d = 1'b0;
    end

    if (byte_done) begin
      if (!rx_valid_q || rx_read_i) begin
        rx_data_d  = rx_byte;
        rx_valid_d = 1'b1;
      end else begin
        overrun_set = 1'b1;
      end
    end

    // Clear first, then let a same-cycle set event win.
    if (status_clr_i) begin
      rx_overrun_d  = 1'b0;
      tx_underrun_d = 1'b0;
    end
    if (overrun_set) begin
      rx_overrun_d = 1'b1;
    end
    if (underrun_set) begin
      tx_underrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      bit_cnt_q     <= 3'd0;
      rx_shift_q    <= 8'h00;
      tx_shift_q    <= 8'h00;
      hold_q        <= 8'h00;
      tx_ready_q    <= 1'b1;
      rx_data_q     <= 8'h00;
      rx_valid_q    <= 1'b0;
      rx_overrun_q  <= 1'b0;
      tx_underrun_q <= 1'b0;
      miso_q        <= 1'b1;
      miso_oe_q     <= 1'b0;
      txn_active_q  <= 1'b0;
      txn_end_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_shift_q    <= rx_shift_d;
      tx_shift_q    <= tx_shift_d;
      hold_q        <= hold_d;
      tx_ready_q    <= tx_ready_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      rx_overrun_q  <= rx_overrun_d;
      tx_underrun_q <= tx_underrun_d;
      miso_q        <= miso_d;
      miso_oe_q     <= miso_oe_d;
      txn_active_q  <= txn_active_d;
      txn_end_q     <= txn_end_d;
    end
  end

  assign spi_miso_o    = miso_q;
  assign spi_miso_oe_o = miso_oe_q;
  assign tx_ready_o    = tx_ready_q;
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign rx_overrun_o  = rx_overrun_q;
  assign tx_underrun_o = tx_underrun_q;
  assign txn_active_o  = txn_active_q;
  assign txn_end_o     = txn_end_q;

endmodule

// File: tb/tb_spi_target_byte.sv
// Bench for spi_target_byte: drives a mode-0 SPI master at SCK = clk/8 and a
// host side, and compares against a byte-level model of the endpoint.
module tb_spi_target_byte;

  localparam int unsigned Half = 4;  // clk cycles per SCK phase

  logic       clk_i        = 1'b0;
  logic       rst_i        = 1'b1;
  logic       spi_cs_n_i   = 1'b1;
  logic       spi_sck_i    = 1'b0;
  logic       spi_mosi_i   = 1'b0;
  logic       spi_miso_o;
  logic       spi_miso_oe_o;
  logic [7:0] tx_data_i    = 8'h00;
  logic       tx_load_i    = 1'b0;
  logic       tx_ready_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_read_i    = 1'b0;
  logic       status_clr_i = 1'b0;
  logic       rx_overrun_o;
  logic       tx_underrun_o;
  logic       txn_active_o;
  logic       txn_end_o;

  always #5 clk_i = ~clk_i;

  spi_target_byte #(
    .SYNC_STAGES(2),
    .FILL_BYTE  (8'hFF)
  ) u_dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .spi_cs_n_i   (spi_cs_n_i),
    .spi_sck_i    (spi_sck_i),
    .spi_mosi_i   (spi_mosi_i),
    .spi_miso_o   (spi_miso_o),
    .spi_miso_oe_o(spi_miso_oe_o),
    .tx_data_i    (tx_data_i),
    .tx_load_i    (tx_load_i),
    .tx_ready_o   (tx_ready_o),
    .rx_data_o    (rx_data_o),
    .rx_valid_o   (rx_valid_o),
    .rx_read_i    (rx_read_i),
    .status_clr_i (status_clr_i),
    .rx_overrun_o (rx_overrun_o),
    .tx_underrun_o(tx_underrun_o),
    .txn_active_o (txn_active_o),
    .txn_end_o    (txn_end_o)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned end_cnt  = 0;

  always @(negedge clk_i) begin
    if (txn_end_o) end_cnt <= end_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Byte-level reference model.
  bit          m_hold_full;
  logic [7:0]  m_hold;
  logic [7:0]  m_rx_data;
  bit          m_rx_valid;
  bit          m_ovr;
  bit          m_udr;
  int unsigned m_ends = 0;

  task automatic m_reset();
    m_hold_full = 1'b0;
    m_hold      = 8'h00;
    m_rx_data   = 8'h00;
    m_rx_valid  = 1'b0;
    m_ovr       = 1'b0;
    m_udr       = 1'b0;
  endtask

  // Next byte the target will shift out; drains the holding register.
  function automatic logic [7:0] m_reload();
    if (m_hold_full) begin
      m_hold_full = 1'b0;
      return m_hold;
    end
    m_udr = 1'b1;
    return 8'hFF;
  endfunction

  function automatic void m_complete(input logic [7:0] b);
    if (!m_rx_valid) begin
      m_rx_data  = b;
      m_rx_valid = 1'b1;
    end else begin
      m_ovr = 1'b1;
    end
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // One clk of host activity; every strobe is applied for exactly one edge.
  task automatic cpu_step(input bit ld, input logic [7:0] ldv, input bit rd, input bit clr);
    check_eq("tx_ready", 32'(tx_ready_o), 32'(!m_hold_full));
    if (rd && m_rx_valid) check_eq("rx_data_read", 32'(rx_data_o), 32'(m_rx_data));
    tx_load_i    = ld;
    tx_data_i    = ldv;
    rx_read_i    = rd;
    status_clr_i = clr;
    tick(1);
    tx_load_i    = 1'b0;
    rx_read_i    = 1'b0;
    status_clr_i = 1'b0;
    if (ld && !m_hold_full) begin
      m_hold      = ldv;
      m_hold_full = 1'b1;
    end
    if (rd) m_rx_valid = 1'b0;
    if (clr) begin
      m_ovr = 1'b0;
      m_udr = 1'b0;
    end
  endtask

  task automatic check_status();
    check_eq("rx_valid", 32'(rx_valid_o), 32'(m_rx_valid));
    check_eq("rx_data", 32'(rx_data_o), 32'(m_rx_data));
    check_eq("rx_overrun", 32'(rx_overrun_o), 32'(m_ovr));
    check_eq("tx_underrun", 32'(tx_underrun_o), 32'(m_udr));
    check_eq("tx_ready_stat", 32'(tx_ready_o), 32'(!m_hold_full));
  endtask

  task automatic check_reset();
    check_eq("rst_miso", 32'(spi_miso_o), 32'd1);
    check_eq("rst_miso_oe", 32'(spi_miso_oe_o), 32'd0);
    check_eq("rst_tx_ready", 32'(tx_ready_o), 32'd1);
    check_eq("rst_rx_data", 32'(rx_data_o), 32'd0);
    check_eq("rst_rx_valid", 32'(rx_valid_o), 32'd0);
    check_eq("rst_rx_overrun", 32'(rx_overrun_o), 32'd0);
    check_eq("rst_tx_underrun", 32'(tx_underrun_o), 32'd0);
    check_eq("rst_txn_active", 32'(txn_active_o), 32'd0);
    check_eq("rst_txn_end", 32'(txn_end_o), 32'd0);
  endtask

  // Master shifts nbits of mo (MSB first) and captures MISO before each rise.
  // Host ops, if any, are issued in the high phase of the 4th bit.
  task automatic xfer_bits(input logic [7:0] mo, input int nbits, input bit ld,
                           input logic [7:0] ldv, input bit rd, input bit clr,
                           output logic [7:0] mi);
    mi = 8'h00;
    for (int k = 0; k < nbits; k++) begin
      spi_mosi_i = mo[7-k];
      tick(Half);
      mi[7-k]   = spi_miso_o;
      spi_sck_i = 1'b1;
      if (k == 3) cpu_step(ld, ldv, rd, clr);
      else tick(1);
      tick(Half - 1);
      spi_sck_i = 1'b0;
    end
    tick(Half);
  endtask

  logic [7:0] mo_a  [8];
  logic [7:0] ldv_a [8];
  bit         ld_a  [8];
  bit         rd_a  [8];
  bit         clr_a [8];

  task automatic clear_ops();
    for (int i = 0; i < 8; i++) begin
      mo_a[i]  = 8'h00;
      ldv_a[i] = 8'h00;
      ld_a[i]  = 1'b0;
      rd_a[i]  = 1'b0;
      clr_a[i] = 1'b0;
    end
  endtask

  // Full CS frame of nb bytes; the last byte may be cut short to last_bits.
  task automatic frame(input int nb, input int last_bits);
    logic [7:0] exp;
    logic [7:0] mi;
    logic [7:0] mask;
    int         bits;
    spi_cs_n_i = 1'b0;
    exp = m_reload();
    tick(6);
    check_eq("txn_active", 32'(txn_active_o), 32'd1);
    check_eq("miso_oe", 32'(spi_miso_oe_o), 32'd1);
    for (int b = 0; b < nb; b++) begin
      bits = (b == nb - 1) ? last_bits : 8;
      xfer_bits(mo_a[b], bits, ld_a[b], ldv_a[b], rd_a[b], clr_a[b], mi);
      mask = 8'hFF;
      mask = mask << (8 - bits);
      check_eq("miso_byte", 32'(mi & mask), 32'(exp & mask));
      if (bits == 8) begin
        m_complete(mo_a[b]);
        exp = m_reload();
      end
      check_status();
    end
    spi_cs_n_i = 1'b1;
    m_ends++;
    tick(6);
    check_eq("txn_end_count", end_cnt, m_ends);
    check_eq("txn_active_idle", 32'(txn_active_o), 32'd0);
    check_eq("miso_oe_idle", 32'(spi_miso_oe_o), 32'd0);
    check_eq("miso_idle", 32'(spi_miso_o), 32'd1);
  endtask

  initial begin
    logic [7:0] exp;
    logic [7:0] mi;
    logic [7:0] tail;
    int         nb;
    int         last;

    m_reset();
    tick(2);
    rst_i = 1'b0;
    check_reset();
    tick(4);

    // T1: single byte both ways.
    clear_ops();
    cpu_step(1'b1, 8'hA5, 1'b0, 1'b0);
    mo_a[0] = 8'h3C;
    frame(1, 8);
    cpu_step(1'b0, 8'h00, 1'b1, 1'b1);

    // T2: 4-byte burst, holding refilled and RX read every byte.
    clear_ops();
    cpu_step(1'b1, 8'hC1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      mo_a[i]  = 8'(i + 1);
      ld_a[i]  = 1'b1;
      ldv_a[i] = 8'(8'hC2 + i);
      rd_a[i]  = 1'b1;
    end
    frame(4, 8);
    cpu_step(1'b0, 8'h00, 1'b1, 1'b0);

    // T3: two bytes with no read -> overrun, then clear.
    clear_ops();
    cpu_step(1'b0, 8'h00, 1'b0, 1'b1);
    mo_a[0] = 8'h11;
    mo_a[1] = 8'h22;
    frame(2, 8);
    cpu_step(1'b0, 8'h00, 1'b0, 1'b1);
    check_status();
    cpu_step(1'b0, 8'h00, 1'b1, 1'b0);

    // T4: empty holding register -> fill byte and underrun.
    clear_ops();
    cpu_step(1'b0, 8'h00, 1'b0, 1'b1);
    mo_a[0] = 8'h67;
    frame(1, 8);
    cpu_step(1'b0, 8'h00, 1'b1, 1'b1);

    // T5: frame aborted after 5 bits, then a clean byte.
    clear_ops();
    cpu_step(1'b1, 8'h6E, 1'b0, 1'b0);
    mo_a[0] = 8'hF0;
    frame(1, 5);
    mo_a[0] = 8'h81;
    frame(1, 8);
    cpu_step(1'b0, 8'h00, 1'b1, 1'b1);

    // T6: reset in the middle of bit 3; rest of that frame must be ignored.
    clear_ops();
    cpu_step(1'b1, 8'h3D, 1'b0, 1'b0);
    spi_cs_n_i = 1'b0;
    exp = m_reload();
    tick(6);
    xfer_bits(8'h96, 3, 1'b0, 8'h00, 1'b0, 1'b0, mi);
    check_eq("t6_miso_pre", 32'(mi & 8'hE0), 32'(exp & 8'hE0));
    rst_i = 1'b1;
    tick(1);
    rst_i = 1'b0;
    m_reset();
    check_reset();
    tail = 8'h96;
    tail = tail << 3;
    xfer_bits(tail, 5, 1'b0, 8'h00, 1'b0, 1'b0, mi);
    check_eq("t6_miso_ignored", 32'(spi_miso_o), 32'd1);
    check_eq("t6_oe_ignored", 32'(spi_miso_oe_o), 32'd0);
    check_eq("t6_rx_valid", 32'(rx_valid_o), 32'd0);
    check_eq("t6_txn_active", 32'(txn_active_o), 32'd0);
    spi_cs_n_i = 1'b1;
    tick(6);
    check_eq("t6_no_txn_end", end_cnt, m_ends);
    clear_ops();
    mo_a[0] = 8'h5A;
    frame(1, 8);
    check_eq("t6_rx_5a", 32'(rx_data_o), 32'h5A);
    cpu_step(1'b0, 8'h00, 1'b1, 1'b1);

    // Randomised frames.
    for (int f = 0; f < 16; f++) begin
      clear_ops();
      nb = int'($urandom_range(1, 4));
      for (int b = 0; b < nb; b++) begin
        mo_a[b]  = 8'($urandom);
        ld_a[b]  = 1'($urandom % 2);
        ldv_a[b] = 8'($urandom);
        rd_a[b]  = ($urandom % 4) != 0;
        clr_a[b] = ($urandom % 8) == 0;
      end
      last = (($urandom % 4) == 0) ? int'($urandom_range(1, 7)) : 8;
      frame(nb, last);
      cpu_step(1'($urandom % 2), 8'($urandom), 1'($urandom % 2), ($urandom % 4) == 0);
      tick(int'($urandom_range(0, 5)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
